// File: rtl/noc_va_pkg.sv
// Shared types and helpers for the VC allocator input stage:
// FSM state encoding, per-class VC mask generation and a one-hot check.
package noc_va_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } va_state_e;

  // Class c owns VCs c*(v/nclass) .. (c+1)*(v/nclass)-1; an out-of-range class owns nothing.
  function automatic logic [MAX_W-1:0] class_mask(input int unsigned v,
                                                  input int unsigned nclass,
                                                  input int unsigned cls);
    logic [MAX_W-1:0] m;
    int unsigned      per;
    m   = '0;
    per = (nclass > 1) ? (v / nclass) : v;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < v) begin
        if (nclass <= 1)
          m[i] = 1'b1;
        else if ((cls < nclass) && ((i / per) == cls))
          m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic is_onehot(input logic [MAX_W-1:0] vec);
    return $onehot(vec);
  endfunction

endpackage

// File: rtl/va_rr_arbiter.sv
// Round-robin arbiter: combinational pick of the first request at or after the
// pointer (wrapping), pointer advanced past the winner only on upd.
module va_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          upd,
  input  logic [IW-1:0] upd_idx,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] r_ptr;
  int            w_idx;
  logic          w_found;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ptr <= '0;
    else if (upd)
      r_ptr <= (int'(upd_idx) == N-1) ? '0 : upd_idx + IW'(1);
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = (int'(r_ptr) + i) % N;
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/va_ivc_stage.sv
// Input-VC stage of the VC allocator: latches a head route, requests one
// class-legal free output VC, and holds the granted VC until the tail leaves.
module va_ivc_stage
  import noc_va_pkg::*;
#(
  parameter int P      = 5,
  parameter int V      = 4,
  parameter int NCLASS = 1,
  parameter int CW     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            route_valid,
  input  logic [P-1:0]    route_port,
  input  logic [CW-1:0]   route_class,
  input  logic [P*V-1:0]  out_vc_avail,
  output logic [P*V-1:0]  va_req,
  input  logic            va_grant,
  input  logic            tail_sent,
  output logic            alloc_valid,
  output logic [P-1:0]    alloc_port,
  output logic [V-1:0]    alloc_vc,
  output logic            err
);

  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int VW = (V > 1) ? $clog2(V) : 1;

  va_state_e       r_state, w_state_nxt;
  logic [P-1:0]    r_port;
  logic [CW-1:0]   r_class;
  logic [P-1:0]    r_alloc_port;
  logic [V-1:0]    r_alloc_vc;
  logic            r_alloc_valid;
  logic            r_err;

  logic [PW-1:0]   w_port_idx;
  logic            w_port_any;
  logic [P-1:0]    w_port_oh;
  logic [V-1:0]    w_mask, w_avail, w_cand, w_gnt;
  logic [VW-1:0]   w_gnt_idx;
  logic [P*V-1:0]  w_va_req;
  logic            w_req_any, w_latch, w_take, w_release, w_route_bad, w_bad_grant;

  // A malformed latched port is reduced to its lowest set bit so at most one slice is requested.
  always_comb begin
    w_port_idx = '0;
    w_port_any = 1'b0;
    w_port_oh  = '0;
    for (int p = P-1; p >= 0; p--) begin
      if (r_port[p]) begin
        w_port_idx = PW'(p);
        w_port_any = 1'b1;
      end
    end
    if (w_port_any)
      w_port_oh[w_port_idx] = 1'b1;
  end

  assign w_mask  = V'(class_mask(V, NCLASS, 32'(r_class)));
  assign w_avail = out_vc_avail[w_port_idx*V +: V];
  assign w_cand  = (w_port_any && (r_state == ST_REQ)) ? (w_mask & w_avail) : '0;

  va_rr_arbiter #(.N(V)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_cand),
    .upd     (w_take),
    .upd_idx (w_gnt_idx),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_va_req = '0;
    w_va_req[w_port_idx*V +: V] = w_gnt;
  end

  assign w_req_any   = |w_gnt;
  assign w_bad_grant = va_grant && !w_req_any;
  assign w_route_bad = !is_onehot(MAX_W'(route_port)) ||
                       ((NCLASS > 1) && (32'(route_class) >= NCLASS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_take      = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (route_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (va_grant && w_req_any) begin
          w_take      = 1'b1;
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (tail_sent) begin
          w_release   = 1'b1;
          w_latch     = route_valid;
          w_state_nxt = route_valid ? ST_REQ : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_port        <= '0;
      r_class       <= '0;
      r_alloc_port  <= '0;
      r_alloc_vc    <= '0;
      r_alloc_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_latch) begin
        r_port  <= route_port;
        r_class <= route_class;
      end
      if (w_take) begin
        r_alloc_port  <= w_port_oh;
        r_alloc_vc    <= w_gnt;
        r_alloc_valid <= 1'b1;
      end else if (w_release) begin
        r_alloc_valid <= 1'b0;
      end
      if (w_bad_grant || (w_latch && w_route_bad))
        r_err <= 1'b1;
    end
  end

  assign va_req      = w_va_req;
  assign alloc_valid = r_alloc_valid;
  assign alloc_port  = r_alloc_port;
  assign alloc_vc    = r_alloc_vc;
  assign err         = r_err;

endmodule

// File: tb/tb_va_ivc_stage.sv
// Directed bench for va_ivc_stage with P=5, V=4, NCLASS=2; expected values
// are hand-derived constants for each vector.
module tb_va_ivc_stage;

  localparam int P = 5;
  localparam int V = 4;
  localparam int NCLASS = 2;
  localparam int CW = 1;

  logic            clk;
  logic            rst;
  logic            route_valid;
  logic [P-1:0]    route_port;
  logic [CW-1:0]   route_class;
  logic [P*V-1:0]  out_vc_avail;
  logic [P*V-1:0]  va_req;
  logic            va_grant;
  logic            tail_sent;
  logic            alloc_valid;
  logic [P-1:0]    alloc_port;
  logic [V-1:0]    alloc_vc;
  logic            err;

  int total = 0;
  int bad   = 0;

  va_ivc_stage #(.P(P), .V(V), .NCLASS(NCLASS), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .route_valid  (route_valid),
    .route_port   (route_port),
    .route_class  (route_class),
    .out_vc_avail (out_vc_avail),
    .va_req       (va_req),
    .va_grant     (va_grant),
    .tail_sent    (tail_sent),
    .alloc_valid  (alloc_valid),
    .alloc_port   (alloc_port),
    .alloc_vc     (alloc_vc),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // At most one request bit may ever be raised.
  always @(negedge clk) begin
    if (!rst)
      chk("popcount", 32'($countones(va_req) <= 1), 32'd1);
  end

  logic [V-1:0] fair_exp [3];

  initial begin
    fair_exp[0] = 4'b0001;
    fair_exp[1] = 4'b0010;
    fair_exp[2] = 4'b0001;

    rst = 1'b1; route_valid = 1'b0; route_port = '0; route_class = '0;
    out_vc_avail = '1; va_grant = 1'b0; tail_sent = 1'b0;
    #12;
    chk("rst_req",   32'(va_req), 32'h0);
    chk("rst_valid", 32'(alloc_valid), 32'h0);
    chk("rst_vc",    32'(alloc_vc), 32'h0);
    chk("rst_err",   32'(err), 32'h0);
    rst = 1'b0;
    tick();

    // Class 1 head to port 2: pointer 0 picks VC2.
    route_valid = 1'b1; route_port = 5'b00100; route_class = 1'b1;
    tick();
    route_valid = 1'b0;
    #1;
    chk("t2_req", 32'(va_req), 32'h00400);
    chk("t2_valid_pre", 32'(alloc_valid), 32'h0);
    va_grant = 1'b1;
    tick();
    va_grant = 1'b0;
    chk("t2_valid", 32'(alloc_valid), 32'h1);
    chk("t2_vc",    32'(alloc_vc), 32'h4);
    chk("t2_port",  32'(alloc_port), 32'h04);
    chk("t2_req_act", 32'(va_req), 32'h0);

    // Asynchronous reset while ACTIVE clears everything at once.
    #2 rst = 1'b1;
    #1;
    chk("t1_valid", 32'(alloc_valid), 32'h0);
    chk("t1_vc",    32'(alloc_vc), 32'h0);
    chk("t1_port",  32'(alloc_port), 32'h0);
    chk("t1_req",   32'(va_req), 32'h0);
    #2 rst = 1'b0;
    route_valid = 1'b1; route_port = 5'b00100; route_class = 1'b1;
    tick();
    route_valid = 1'b0;
    #1;
    chk("t1_rereq", 32'(va_req), 32'h00400);
    va_grant = 1'b1;
    tick();
    va_grant = 1'b0;
    tail_sent = 1'b1;
    tick();
    tail_sent = 1'b0;
    chk("t1_idle_valid", 32'(alloc_valid), 32'h0);
    chk("t1_idle_req",   32'(va_req), 32'h0);

    // Fairness within class 0 (pointer is 3 after the VC2 grant).
    for (int k = 0; k < 3; k++) begin
      route_valid = 1'b1; route_port = 5'b00001; route_class = 1'b0;
      tick();
      route_valid = 1'b0;
      #1;
      chk($sformatf("t3_req%0d", k), 32'(va_req), 32'(fair_exp[k]));
      va_grant = 1'b1;
      tick();
      va_grant = 1'b0;
      chk($sformatf("t3_vc%0d", k), 32'(alloc_vc), 32'(fair_exp[k]));
      tail_sent = 1'b1;
      tick();
      tail_sent = 1'b0;
    end

    // Port 1 unavailable for 10 cycles, then only VC1 frees up.
    out_vc_avail = '1;
    out_vc_avail[7:4] = 4'b0000;
    route_valid = 1'b1; route_port = 5'b00010; route_class = 1'b0;
    tick();
    route_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("t4_stall%0d", c), 32'(va_req), 32'h0);
      tick();
    end
    out_vc_avail[7:4] = 4'b0010;
    #1;
    chk("t4_req", 32'(va_req), 32'h00020);
    va_grant = 1'b1;
    tick();
    va_grant = 1'b0;
    out_vc_avail = '1;
    chk("t4_vc",  32'(alloc_vc), 32'h2);
    chk("t4_err", 32'(err), 32'h0);

    // Tail and new head in the same cycle: straight to REQ.
    tail_sent = 1'b1; route_valid = 1'b1; route_port = 5'b10000; route_class = 1'b0;
    tick();
    tail_sent = 1'b0; route_valid = 1'b0;
    #1;
    chk("t5_valid", 32'(alloc_valid), 32'h0);
    chk("t5_req",   32'(va_req), 32'h10000);
    va_grant = 1'b1;
    tick();
    va_grant = 1'b0;
    chk("t5_port", 32'(alloc_port), 32'h10);
    chk("t5_vc",   32'(alloc_vc), 32'h1);
    tail_sent = 1'b1;
    tick();
    tail_sent = 1'b0;

    // Spurious grant in IDLE.
    va_grant = 1'b1;
    tick();
    va_grant = 1'b0;
    chk("t6_err_grant", 32'(err), 32'h1);
    chk("t6_idle_valid", 32'(alloc_valid), 32'h0);
    chk("t6_idle_req",   32'(va_req), 32'h0);

    // Non-one-hot route after clearing err.
    rst = 1'b1;
    #1;
    chk("t6_err_clr", 32'(err), 32'h0);
    rst = 1'b0;
    route_valid = 1'b1; route_port = 5'b00110; route_class = 1'b0;
    tick();
    route_valid = 1'b0;
    #1;
    chk("t6_err_port", 32'(err), 32'h1);
    chk("t6_req",      32'(va_req), 32'h00010);
    va_grant = 1'b1;
    tick();
    va_grant = 1'b0;
    chk("t6_aport", 32'(alloc_port), 32'h02);
    chk("t6_avc",   32'(alloc_vc), 32'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/va_ivc_stage.md
Name: va_ivc_stage

Overview:
- Parametrised, stateful input-VC stage of the VC allocator; one instance per input VC.
- Latches the route computed for a head flit and masks candidate output VCs by message class and downstream availability.
- A local round-robin arbiter picks one candidate, which is presented as a one-hot request to the main (output-side) allocator.
- After a grant, holds the allocated output VC until the packet's tail departs; then releases it, back-to-back if a new head is waiting.

Parameters:
- P, 5, number of router ports.
- V, 4, VCs per port; must be a multiple of NCLASS.
- NCLASS, 1, message classes; class c owns VCs c*(V/NCLASS) .. (c+1)*(V/NCLASS)-1.
- CW, 1, class field width; must be >= 1 and >= clog2(NCLASS).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- route_valid  in  1  head flit at this IVC has a route; sampled in IDLE, and in ACTIVE when tail_sent=1.
- route_port  in  P  one-hot output port for the head flit.
- route_class  in  CW  message class of the packet.
- out_vc_avail  in  P*V  bit i*V+j = port i VC j is free.
- va_req  out  P*V  one-hot (or zero) request to main allocator; same bit layout.
- va_grant  in  1  main allocator granted the request shown on va_req this cycle.
- tail_sent  in  1  tail flit of the current packet left the switch.
- alloc_valid  out  1  an output VC is held.
- alloc_port  out  P  held output port, one-hot.
- alloc_vc  out  V  held output VC, one-hot.
- err  out  1  sticky protocol-error flag.

Behaviour:
- States: IDLE, REQ, ACTIVE.
- Reset (asynchronous, any state): state=IDLE, RR pointer=0, latched port/class=0, alloc_port=0, alloc_vc=0, alloc_valid=0, err=0, va_req=0.
- IDLE:
  - route_valid=1 latches route_port/route_class; next state REQ.
  - route_valid=0: stay IDLE.
- REQ:
  - cand = class_mask(latched class) & out_vc_avail slice of the latched port.
  - Arbiter selects the first set bit of cand at or after the RR pointer, wrapping V-1 -> 0.
  - va_req = selection placed in the latched port's slice; combinational from registers and out_vc_avail (zero added latency).
  - cand=0: va_req=0; stay REQ indefinitely (no timeout).
  - va_grant=1 with va_req!=0: alloc_vc <= selection; alloc_port <= latched port; alloc_valid <= 1 next cycle; RR pointer <= (granted index+1) mod V; next state ACTIVE.
  - va_grant=0: pointer unchanged; re-request next cycle (availability may change).
- ACTIVE:
  - va_req=0; alloc_* held stable.
  - tail_sent=0: stay ACTIVE.
  - tail_sent=1 and route_valid=0: next IDLE; alloc_valid=0 from next cycle.
  - tail_sent=1 and route_valid=1: latch the new route; next REQ (back-to-back, no IDLE bubble); alloc_valid=0 next cycle.
- Ignored inputs:
  - tail_sent outside ACTIVE.
  - route_valid in REQ, and in ACTIVE without tail_sent.
- Errors (err set, sticky until reset; state machine otherwise unaffected):
  - va_grant=1 while va_req=0, in any state; the grant is dropped.
  - route_port not one-hot when sampled; route still latched, and va_req stays masked to at most one bit.
  - route_class >= NCLASS when sampled; cand forced to 0, so the IVC stalls in REQ.
- NCLASS=1: class mask is all ones; route_class is don't-care.
- Invariants: popcount(va_req) <= 1; alloc_valid=1 iff state=ACTIVE.
- Grant latency: request at cycle t, grant at t -> alloc_valid=1 at t+1.

Decomposition:
- Shared package noc_va_pkg holds:
  - state encoding (IDLE=2'd0, REQ=2'd1, ACTIVE=2'd2);
  - class-mask generation function;
  - onehot-check function.
- One sub-module: va_rr_arbiter (parameter N; inputs req[N], upd, upd_idx; outputs gnt[N], gnt_idx).
  - Combinational pick; pointer register advanced only when upd=1.
  - Reset is asynchronous, active-high.

Test Plan (P=5, V=4, NCLASS=2):
1. Reset mid-ACTIVE (alloc_vc=4'b0100): assert rst asynchronously -> all outputs 0 immediately, state IDLE; same route re-requests from pointer 0.
2. route_valid, port=5'b00100, class 1, out_vc_avail all ones, grant in first REQ cycle -> va_req=20'h00400 (port 2 VC 2); alloc_vc=4'b0100, alloc_valid=1 one cycle later.
3. Fairness: same IVC, class 0, avail all ones, three packets each granted -> alloc_vc sequence 0001, 0010, 0001 (pointer wraps within class).
4. Port 1 avail=4'b0000 for 10 cycles, then 4'b0010, class 0 -> va_req=0 for 10 cycles, then 20'h00020; err stays 0.
5. ACTIVE with tail_sent=1 and route_valid=1 (port 5'b10000) same cycle -> next cycle state REQ, alloc_valid=0, va_req nonzero in port 4 slice; no IDLE cycle.
6. va_grant=1 in IDLE -> err=1, state stays IDLE; route_port=5'b00110 -> err=1 and popcount(va_req) <= 1 throughout.
